tia_horizontal_counter: RTL and testbench

TIA_HORIZONTAL_COUNTER -- requirements
Module: tia_horizontal_counter

---
 rtl/tia_pkg.sv | 45 ++++
 rtl/tia_lfsr6.sv | 34 +++
 rtl/tia_horizontal_counter.sv | 141 ++++++++++++++
 tb/tb_tia_horizontal_counter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tia_pkg                                                    |
// | Description : Shared constants, types and LFSR helpers for the TIA       |
// |               horizontal timing chain and the object position counters.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package tia_pkg;

   // Counter geometry
   localparam int C_LFSR_W   = 6;
   localparam int C_PHASE_W  = 2;
   localparam int C_WRAP_IDX = 56;

   typedef logic [C_LFSR_W-1:0]  lfsr_t;
   typedef logic [C_PHASE_W-1:0] phase_t;

   // Phase values of interest within one 4-clk counter slot
   localparam phase_t C_PHASE_PHI1    = 2'd0;
   localparam phase_t C_PHASE_PHI2    = 2'd2;
   localparam phase_t C_PHASE_PRE_ADV = 2'd2;
   localparam phase_t C_PHASE_ADV     = 2'd3;
   localparam phase_t C_PHASE_STEP    = 2'd1;

   // LFSR codes for the count indices that the horizontal decodes care about
   localparam lfsr_t C_CODE_N0   = 6'b000000;  // line start, hblank on
   localparam lfsr_t C_CODE_N4   = 6'b001111;  // hsync on
   localparam lfsr_t C_CODE_N8   = 6'b111011;  // hsync off, colour burst on
   localparam lfsr_t C_CODE_N12  = 6'b111100;  // colour burst off
   localparam lfsr_t C_CODE_N16  = 6'b001110;  // hblank off (normal)
   localparam lfsr_t C_CODE_N18  = 6'b111010;  // hblank off (HMOVE extended)
   localparam lfsr_t C_CODE_WRAP = 6'b001010;  // index 56, last slot of a line

   // Raw polynomial step with XNOR feedback (all-ones is the lockup state)
   function automatic lfsr_t lfsr_step(input lfsr_t q);
      return {q[C_LFSR_W-2:0], q[C_LFSR_W-1] ~^ q[C_LFSR_W-2]};
   endfunction

   // Step including the early wrap: the wrap code reloads the start code
   function automatic lfsr_t lfsr_next(input lfsr_t q);
      return (q == C_CODE_WRAP) ? C_CODE_N0 : lfsr_step(q);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tia_lfsr6.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tia_lfsr6                                                  |
// | Description : 6-bit polynomial counter with 57-state early wrap. Shared  |
// |               by the horizontal counter and object position counters.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tia_lfsr6
   import tia_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                advance,
   output logic [C_LFSR_W-1:0] q
);

   lfsr_t r_q;

   // Counter state: clear wins over advance so a resync always lands on the start code
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= C_CODE_N0;
      end else if (clear) begin
         r_q <= C_CODE_N0;
      end else if (advance) begin
         r_q <= lfsr_next(r_q);
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tia_horizontal_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tia_horizontal_counter                                     |
// | Description : TIA horizontal timing: 4-phase clock divider, 57-slot      |
// |               polynomial line counter, registered hsync/hblank/cburst    |
// |               decodes, HMOVE blank extension and end-of-line strobe.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tia_horizontal_counter
   import tia_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                rsyn,
   input  logic                hmove,
   output logic                hphi1,
   output logic                hphi2,
   output logic [C_LFSR_W-1:0] hcount,
   output logic                hsync,
   output logic                hblank,
   output logic                cburst,
   output logic                line_end
);

   phase_t r_phase;
   logic   r_hmove_latch;
   logic   r_hblank;
   logic   r_hsync;
   logic   r_cburst;
   logic   r_line_end;

   lfsr_t  w_hcount;
   lfsr_t  w_next_code;
   logic   w_advance;
   logic   w_enter_n0;
   logic   w_pre_line_end;

   // Advance only in the last phase slot; a resync pre-empts the advance
   assign w_advance      = (r_phase == C_PHASE_ADV) && !rsyn;
   // Code the counter is about to enter, used so decodes register on the same edge
   assign w_next_code    = lfsr_next(w_hcount);
   assign w_enter_n0     = w_advance && (w_next_code == C_CODE_N0);
   // One clk before the final slot of the line, so line_end lines up with it
   assign w_pre_line_end = (r_phase == C_PHASE_PRE_ADV) && (w_hcount == C_CODE_WRAP) && !rsyn;

   // Phase divider: free-running modulo 4, parked at 0 while resync is held
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= '0;
      end else if (rsyn) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + C_PHASE_STEP;
      end
   end

   tia_lfsr6 u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .clear   (rsyn),
      .advance (w_advance),
      .q       (w_hcount)
   );

   // HMOVE latch: any strobe sets it; the line wrap clears it unless a strobe lands there too
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hmove_latch <= 1'b0;
      end else if (hmove) begin
         r_hmove_latch <= 1'b1;
      end else if (w_enter_n0) begin
         r_hmove_latch <= 1'b0;
      end
   end

   // Horizontal blank: on at line start, off at index 16 or 18 when HMOVE is pending
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hblank <= 1'b1;
      end else if (rsyn) begin
         r_hblank <= 1'b1;
      end else if (w_advance) begin
         if (w_next_code == C_CODE_N0) begin
            r_hblank <= 1'b1;
         end else if ((w_next_code == C_CODE_N16) && !r_hmove_latch) begin
            r_hblank <= 1'b0;
         end else if ((w_next_code == C_CODE_N18) && r_hmove_latch) begin
            r_hblank <= 1'b0;
         end
      end
   end

   // Horizontal sync window: indices 4 through 7
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hsync <= 1'b0;
      end else if (rsyn) begin
         r_hsync <= 1'b0;
      end else if (w_advance) begin
         if (w_next_code == C_CODE_N4) begin
            r_hsync <= 1'b1;
         end else if (w_next_code == C_CODE_N8) begin
            r_hsync <= 1'b0;
         end
      end
   end

   // Colour-burst gate window: indices 8 through 11
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cburst <= 1'b0;
      end else if (rsyn) begin
         r_cburst <= 1'b0;
      end else if (w_advance) begin
         if (w_next_code == C_CODE_N8) begin
            r_cburst <= 1'b1;
         end else if (w_next_code == C_CODE_N12) begin
            r_cburst <= 1'b0;
         end
      end
   end

   // End-of-line strobe: high for the single clk at the last phase of index 56
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_line_end <= 1'b0;
      end else begin
         r_line_end <= w_pre_line_end;
      end
   end

   assign hphi1    = (r_phase == C_PHASE_PHI1);
   assign hphi2    = (r_phase == C_PHASE_PHI2);
   assign hcount   = w_hcount;
   assign hsync    = r_hsync;
   assign hblank   = r_hblank;
   assign cburst   = r_cburst;
   assign line_end = r_line_end;

endmodule
`default_nettype wire

// File: tb/tb_tia_horizontal_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tia_horizontal_counter                                  |
// | Description : Self-checking bench for tia_horizontal_counter: directed   |
// |               line-timing scenarios plus randomized hmove/rsyn/reset     |
// |               traffic against an index-based behavioural model.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tia_horizontal_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       rsyn;
   logic       hmove;
   logic       hphi1;
   logic       hphi2;
   logic [5:0] hcount;
   logic       hsync;
   logic       hblank;
   logic       cburst;
   logic       line_end;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   tia_horizontal_counter dut (
      .clk      (clk),
      .reset    (reset),
      .rsyn     (rsyn),
      .hmove    (hmove),
      .hphi1    (hphi1),
      .hphi2    (hphi2),
      .hcount   (hcount),
      .hsync    (hsync),
      .hblank   (hblank),
      .cburst   (cburst),
      .line_end (line_end)
   );

   // Reference: count index 0..56, phase 0..3, codes derived from the polynomial rule
   logic [5:0] code [0:56];
   int         m_n;
   int         m_phase;
   logic       m_latch;
   logic       m_late;

   initial begin
      code[0] = 6'b000000;
      for (int i = 1; i < 57; i++)
         code[i] = {code[i-1][4:0], ~(code[i-1][5] ^ code[i-1][4])};
   end

   // Model state update on each rising clk (or async reset)
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase <= 0;
         m_n     <= 0;
         m_latch <= 1'b0;
         m_late  <= 1'b0;
      end else if (rsyn) begin
         m_phase <= 0;
         m_n     <= 0;
         m_latch <= m_latch | hmove;
      end else begin
         m_phase <= (m_phase + 1) % 4;
         if (m_phase == 3) begin
            m_n <= (m_n == 56) ? 0 : m_n + 1;
            if (m_n == 15) m_late <= m_latch;
         end
         m_latch <= hmove | (m_latch & !(m_phase == 3 && m_n == 56));
      end
   end

   // Continuous comparison of all outputs against the model, on the falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if ({hcount, hphi1, hphi2, hsync, hblank, cburst, line_end} !==
             {code[m_n], (m_phase == 0), (m_phase == 2), (m_n >= 4 && m_n < 8),
              ((m_n < 16) || (m_late && m_n < 18)), (m_n >= 8 && m_n < 12),
              (m_n == 56 && m_phase == 3)}) begin
            failures++;
            $display("FAIL model t=%0t got hc=%b p1=%b p2=%b hs=%b hb=%b cb=%b le=%b need hc=%b n=%0d ph=%0d late=%b",
                     $time, hcount, hphi1, hphi2, hsync, hblank, cburst, line_end,
                     code[m_n], m_n, m_phase, m_late);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got %0h need %0h", nm, $time, act, exp);
      end
   endtask

   // Pulse reset across one falling edge; the next rising edge is clk 1
   task automatic restart();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   bit seen [0:63];
   int distinct;
   int rsyn_left;

   initial begin
      reset = 1'b1;
      rsyn  = 1'b0;
      hmove = 1'b0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_hphi1",  hphi1,    1);
      chk("rst_hphi2",  hphi2,    0);
      chk("rst_hcount", hcount,   0);
      chk("rst_hblank", hblank,   1);
      chk("rst_hsync",  hsync,    0);
      chk("rst_cburst", cburst,   0);
      chk("rst_le",     line_end, 0);

      // Basic line timing over 2.5 lines
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      distinct = 0;
      reset = 1'b0;
      for (int k = 1; k <= 570; k++) begin
         @(negedge clk);
         if (k <= 228 && !seen[hcount]) begin
            seen[hcount] = 1'b1;
            distinct++;
         end
         case (k)
            1:   chk("a_hphi1_k1", hphi1, 0);
            2:   chk("a_hphi2_k2", hphi2, 1);
            3:   chk("a_hc_k3",    hcount, 6'b000000);
            4:   chk("a_hc_n1",    hcount, 6'b000001);
            15:  chk("a_hs_15",    hsync, 0);
            16:  begin chk("a_hs_16", hsync, 1); chk("a_hc_n4", hcount, 6'b001111); end
            31:  chk("a_hs_31",    hsync, 1);
            32:  begin chk("a_hs_32", hsync, 0); chk("a_cb_32", cburst, 1); end
            47:  chk("a_cb_47",    cburst, 1);
            48:  begin chk("a_cb_48", cburst, 0); chk("a_hc_n12", hcount, 6'b111100); end
            63:  chk("a_hb_63",    hblank, 1);
            64:  begin chk("a_hb_64", hblank, 0); chk("a_hc_n16", hcount, 6'b001110); end
            224: chk("a_hc_n56",   hcount, 6'b001010);
            226: chk("a_le_226",   line_end, 0);
            227: chk("a_le_227",   line_end, 1);
            228: begin
                    chk("a_hc_228", hcount, 0);
                    chk("a_le_228", line_end, 0);
                    chk("a_hb_228", hblank, 1);
                    chk("a_distinct", distinct, 57);
                 end
            455: chk("a_le_455",   line_end, 1);
            default: ;
         endcase
      end

      // HMOVE early in the line extends blank to index 18 for that line only
      restart();
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         case (k)
            64:  chk("b_hb_64",  hblank, 1);
            71:  chk("b_hb_71",  hblank, 1);
            72:  chk("b_hb_72",  hblank, 0);
            291: chk("b_hb_291", hblank, 1);
            292: chk("b_hb_292", hblank, 0);
            default: ;
         endcase
         hmove = (k == 9);
      end

      // HMOVE on the line_end clk carries into the next line
      restart();
      for (int k = 1; k <= 520; k++) begin
         @(negedge clk);
         case (k)
            227: chk("c_le_227", line_end, 1);
            292: chk("c_hb_292", hblank, 1);
            299: chk("c_hb_299", hblank, 1);
            300: chk("c_hb_300", hblank, 0);
            519: chk("c_hb_519", hblank, 1);
            520: chk("c_hb_520", hblank, 0);
            default: ;
         endcase
         hmove = (k == 227);
      end

      // Resync mid-line restarts the line
      restart();
      for (int k = 1; k <= 330; k++) begin
         @(negedge clk);
         case (k)
            99:  chk("d_hb_99",  hblank, 0);
            100: begin
                    chk("d_hc_100", hcount, 0);
                    chk("d_hb_100", hblank, 1);
                    chk("d_hs_100", hsync,  0);
                    chk("d_p1_100", hphi1,  1);
                 end
            227: chk("d_le_227", line_end, 0);
            326: chk("d_le_326", line_end, 0);
            327: chk("d_le_327", line_end, 1);
            328: chk("d_hc_328", hcount, 0);
            default: ;
         endcase
         rsyn = (k == 99);
      end

      // Asynchronous reset during hsync, then line timing repeats
      restart();
      repeat (20) @(negedge clk);
      chk("e_hs_pre", hsync, 1);
      #2 reset = 1'b1;
      #1;
      chk("e_hs_async", hsync,  0);
      chk("e_hb_async", hblank, 1);
      chk("e_hc_async", hcount, 0);
      chk("e_p1_async", hphi1,  1);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 228; k++) begin
         @(negedge clk);
         case (k)
            15:  chk("e_hs_15",  hsync, 0);
            16:  chk("e_hs_16",  hsync, 1);
            32:  chk("e_hs_32",  hsync, 0);
            64:  chk("e_hb_64",  hblank, 0);
            227: chk("e_le_227", line_end, 1);
            228: chk("e_hc_228", hcount, 0);
            default: ;
         endcase
      end

      // Randomized hmove / rsyn (including held rsyn) / async reset traffic
      rsyn_left = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         hmove = ($urandom_range(0, 39) == 0);
         if (rsyn_left > 0) begin
            rsyn = 1'b1;
            rsyn_left--;
         end else if ($urandom_range(0, 399) == 0) begin
            rsyn = 1'b1;
            rsyn_left = $urandom_range(0, 5);
         end else begin
            rsyn = 1'b0;
         end
         if ($urandom_range(0, 1499) == 0) begin
            #($urandom_range(1, 4)) reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
